// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer controller: state encoding and one-hot helper.
package bus_ctrl_pkg;

    localparam int MAX_REGS  = 16;
    localparam int MAX_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Indices at or beyond width decode to all-zero so out-of-range selects never drive a line.
    function automatic logic [MAX_REGS-1:0] onehot(input logic [MAX_SEL_W-1:0] index,
                                                   input int width);
        logic [MAX_REGS-1:0] v;
        v = '0;
        if (int'(index) < width) v[index] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Gated index-to-one-hot decoder feeding the register bank enable registers.
module onehot_decoder #(
    parameter int SEL_W    = 2,
    parameter int NUM_REGS = 4
) (
    input  logic [SEL_W-1:0]    index,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot_out
);
    import bus_ctrl_pkg::*;

    logic [MAX_SEL_W-1:0] idx_ext;

    assign idx_ext    = MAX_SEL_W'(index);
    assign onehot_out = en ? NUM_REGS'(onehot(idx_ext, NUM_REGS)) : '0;

endmodule

// File: rtl/bus_transfer_controller.sv
// Sequences one register-to-register move on the shared 1-bit bus per request.
// Optional transfer counter output enabled by defining XFER_COUNT_EN.
//
// state    | meaning
// ST_IDLE  | ready for a request; rejects set err for one cycle
// ST_DRIVE | source drives the bus, bus settles
// ST_LATCH | source still driving, destination captures on the closing edge
// ST_DONE  | enables released, done pulses
module bus_transfer_controller #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    input  logic [SEL_W-1:0]    req_src,
    input  logic [SEL_W-1:0]    req_dst,
    output logic                req_ready,
    output logic [NUM_REGS-1:0] output_enable,
    output logic [NUM_REGS-1:0] input_enable,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef XFER_COUNT_EN
    ,
    output logic [7:0]          xfer_count
`endif
);
    import bus_ctrl_pkg::*;

    state_t              state;
    logic [SEL_W-1:0]    src_q;
    logic [SEL_W-1:0]    dst_q;
    logic                req_ok;
    logic [SEL_W-1:0]    src_idx;
    logic                src_en;
    logic                dst_en;
    logic [NUM_REGS-1:0] src_oh;
    logic [NUM_REGS-1:0] dst_oh;

    assign req_ready = (state == ST_IDLE);

    assign req_ok = (req_src != req_dst)
                 && (int'(req_src) < NUM_REGS)
                 && (int'(req_dst) < NUM_REGS);

    // In IDLE the source decoder looks at the live request so DRIVE's enable is ready at the accept edge.
    assign src_idx = (state == ST_IDLE) ? req_src : src_q;
    assign src_en  = (state == ST_IDLE) ? (req_valid && req_ok) : (state == ST_DRIVE);
    assign dst_en  = (state == ST_DRIVE);

    onehot_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_src_dec (
        .index      (src_idx),
        .en         (src_en),
        .onehot_out (src_oh)
    );

    onehot_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dst_dec (
        .index      (dst_q),
        .en         (dst_en),
        .onehot_out (dst_oh)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            output_enable <= '0;
            input_enable  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_ok) begin
                            state         <= ST_DRIVE;
                            src_q         <= req_src;
                            dst_q         <= req_dst;
                            output_enable <= src_oh;
                            busy          <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    state         <= ST_LATCH;
                    output_enable <= src_oh;
                    input_enable  <= dst_oh;
                end
                ST_LATCH: begin
                    state         <= ST_DONE;
                    output_enable <= '0;
                    input_enable  <= '0;
                    done          <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef XFER_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count <= 8'd0;
        end else if (state == ST_DONE) begin
            xfer_count <= xfer_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Directed bench for bus_transfer_controller with a behavioural 1-bit register bank on the bus.
module tb_bus_transfer_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic [1:0] req_src;
    logic [1:0] req_dst;
    logic       req_ready;
    logic [3:0] output_enable;
    logic [3:0] input_enable;
    logic       busy;
    logic       done;
    logic       err;
`ifdef XFER_COUNT_EN
    logic [7:0] xfer_count;
    logic [7:0] xfer_count3;
`endif

    logic       req_valid3;
    logic [1:0] req_src3;
    logic [1:0] req_dst3;
    logic       req_ready3;
    logic [2:0] oe3;
    logic [2:0] ie3;
    logic       busy3;
    logic       done3;
    logic       err3;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    bus_transfer_controller #(.NUM_REGS(4), .SEL_W(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_ready     (req_ready),
        .output_enable (output_enable),
        .input_enable  (input_enable),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef XFER_COUNT_EN
        ,
        .xfer_count    (xfer_count)
`endif
    );

    bus_transfer_controller #(.NUM_REGS(3), .SEL_W(2)) dut3 (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid3),
        .req_src       (req_src3),
        .req_dst       (req_dst3),
        .req_ready     (req_ready3),
        .output_enable (oe3),
        .input_enable  (ie3),
        .busy          (busy3),
        .done          (done3),
        .err           (err3)
`ifdef XFER_COUNT_EN
        ,
        .xfer_count    (xfer_count3)
`endif
    );

    // Register bank: whoever has output_enable drives the wire, input_enable captures on posedge.
    logic [3:0] bank;
    logic [3:0] bank_init;
    logic       bank_load;
    logic       bus;

    assign bus = |(bank & output_enable);

    always @(posedge clk) begin
        if (bank_load) bank <= bank_init;
        else begin
            for (int i = 0; i < 4; i++)
                if (input_enable[i]) bank[i] <= bus;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            compared++;
            if ($countones(output_enable) > 1 || $countones(input_enable) > 1 ||
                (input_enable != 0 && output_enable == 0) ||
                (output_enable & input_enable) != 0) begin
                failed++;
                $display("FAIL invariant: oe=%b ie=%b", output_enable, input_enable);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] src;
        logic [1:0] dst;
        logic       rej;
        logic [3:0] oe;
        logic [3:0] ie;
        logic [3:0] bank_after;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = v.src;
        req_dst   = v.dst;
        @(negedge clk);
        req_valid = 1'b0;
        if (v.rej) begin
            check("rej_err", 32'(err), 1);
            check("rej_oe", 32'(output_enable), 0);
            check("rej_ie", 32'(input_enable), 0);
            check("rej_ready", 32'(req_ready), 1);
            check("rej_busy", 32'(busy), 0);
            @(negedge clk);
            check("rej_err_clr", 32'(err), 0);
            check("rej_bank", 32'(bank), 32'(v.bank_after));
        end else begin
            check("drive_oe", 32'(output_enable), 32'(v.oe));
            check("drive_ie", 32'(input_enable), 0);
            check("drive_busy", 32'(busy), 1);
            check("drive_ready", 32'(req_ready), 0);
            @(negedge clk);
            check("latch_oe", 32'(output_enable), 32'(v.oe));
            check("latch_ie", 32'(input_enable), 32'(v.ie));
            check("latch_done", 32'(done), 0);
            @(negedge clk);
            check("done_pulse", 32'(done), 1);
            check("done_oe", 32'(output_enable), 0);
            check("done_ie", 32'(input_enable), 0);
            check("done_busy", 32'(busy), 1);
            check("done_ready", 32'(req_ready), 0);
            check("bank", 32'(bank), 32'(v.bank_after));
            @(negedge clk);
            check("idle_done", 32'(done), 0);
            check("idle_ready", 32'(req_ready), 1);
            check("idle_busy", 32'(busy), 0);
        end
    endtask

`ifdef XFER_COUNT_EN
    task automatic quick_xfer(input logic [1:0] s, input logic [1:0] d, input logic rej);
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        @(negedge clk);
        req_valid = 1'b0;
        if (!rej) repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        // Bank starts as reg0=1, reg2=1.
        vecs[0] = '{src: 2'd0, dst: 2'd3, rej: 1'b0, oe: 4'b0001, ie: 4'b1000, bank_after: 4'b1101};
        vecs[1] = '{src: 2'd2, dst: 2'd2, rej: 1'b1, oe: 4'b0000, ie: 4'b0000, bank_after: 4'b1101};
        vecs[2] = '{src: 2'd1, dst: 2'd2, rej: 1'b0, oe: 4'b0010, ie: 4'b0100, bank_after: 4'b1001};
        vecs[3] = '{src: 2'd3, dst: 2'd1, rej: 1'b0, oe: 4'b1000, ie: 4'b0010, bank_after: 4'b1011};
        vecs[4] = '{src: 2'd2, dst: 2'd0, rej: 1'b0, oe: 4'b0100, ie: 4'b0001, bank_after: 4'b1010};
        vecs[5] = '{src: 2'd1, dst: 2'd1, rej: 1'b1, oe: 4'b0000, ie: 4'b0000, bank_after: 4'b1010};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_src    = '0;
        req_dst    = '0;
        req_valid3 = 1'b0;
        req_src3   = '0;
        req_dst3   = '0;
        bank_load  = 1'b1;
        bank_init  = 4'b0101;
        repeat (2) @(negedge clk);
        check("rst_oe", 32'(output_enable), 0);
        check("rst_ie", 32'(input_enable), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        reset_n   = 1'b1;
        bank_load = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back with req_valid held: 0->1 then 1->2, second accept four edges after the first.
        bank_load = 1'b1;
        bank_init = 4'b0001;
        @(negedge clk);
        bank_load = 1'b0;
        req_valid = 1'b1;
        req_src   = 2'd0;
        req_dst   = 2'd1;
        @(negedge clk);
        check("b2b_drive1_oe", 32'(output_enable), 32'h1);
        req_src = 2'd1;
        req_dst = 2'd2;
        @(negedge clk);
        check("b2b_latch1_ie", 32'(input_enable), 32'h2);
        check("b2b_latch1_oe", 32'(output_enable), 32'h1);
        @(negedge clk);
        check("b2b_done1", 32'(done), 1);
        check("b2b_bank1", 32'(bank), 32'h3);
        @(negedge clk);
        check("b2b_idle_ready", 32'(req_ready), 1);
        check("b2b_idle_oe", 32'(output_enable), 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_drive2_oe", 32'(output_enable), 32'h2);
        @(negedge clk);
        check("b2b_latch2_ie", 32'(input_enable), 32'h4);
        @(negedge clk);
        check("b2b_done2", 32'(done), 1);
        check("b2b_bank2", 32'(bank), 32'h7);
        @(negedge clk);

        // Source change during DRIVE must not move the driving register.
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = 2'd1;
        req_dst   = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        req_src   = 2'd3;
        req_dst   = 2'd2;
        check("chg_drive_oe", 32'(output_enable), 32'h2);
        @(negedge clk);
        check("chg_latch_oe", 32'(output_enable), 32'h2);
        check("chg_latch_ie", 32'(input_enable), 32'h1);
        repeat (2) @(negedge clk);
        check("chg_ready", 32'(req_ready), 1);

        // Reset asserted during LATCH drops enables without a clock edge.
        @(negedge clk);
        req_valid = 1'b1;
        req_src   = 2'd1;
        req_dst   = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_latch_ie", 32'(input_enable), 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_oe", 32'(output_enable), 0);
        check("mid_rst_ie", 32'(input_enable), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", 32'(req_ready), 1);
        check("mid_rel_done", 32'(done), 0);

        // Three-register instance: index 3 is out of range.
        @(negedge clk);
        req_valid3 = 1'b1;
        req_src3   = 2'd0;
        req_dst3   = 2'd3;
        @(negedge clk);
        req_valid3 = 1'b0;
        check("n3_dst_err", 32'(err3), 1);
        check("n3_dst_oe", 32'(oe3), 0);
        @(negedge clk);
        check("n3_err_clr", 32'(err3), 0);
        req_valid3 = 1'b1;
        req_src3   = 2'd3;
        req_dst3   = 2'd0;
        @(negedge clk);
        req_valid3 = 1'b0;
        check("n3_src_err", 32'(err3), 1);
        @(negedge clk);
        req_valid3 = 1'b1;
        req_src3   = 2'd2;
        req_dst3   = 2'd0;
        @(negedge clk);
        req_valid3 = 1'b0;
        check("n3_ok_oe", 32'(oe3), 32'h4);
        check("n3_ok_err", 32'(err3), 0);
        @(negedge clk);
        check("n3_ok_ie", 32'(ie3), 32'h1);
        repeat (2) @(negedge clk);

`ifdef XFER_COUNT_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("cnt_rst", 32'(xfer_count), 0);
        for (int i = 0; i < 260; i++) begin
            if (i % 87 == 50) quick_xfer(2'(i % 4), 2'(i % 4), 1'b1);
            else              quick_xfer(2'(i % 4), 2'((i + 1) % 4), 1'b0);
        end
        @(negedge clk);
        check("cnt_wrap", 32'(xfer_count), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
